// File: rtl/image_scanout.sv
// image_scanout: VGA-class raster generator that addresses a 64x64 RGB333 image ROM,
// replicates it onto the screen and realigns ROM data with delayed sync/blanking.
module image_scanout #(
    parameter int         H_ACTIVE    = 640,
    parameter int         H_FP        = 16,
    parameter int         H_SYNC      = 96,
    parameter int         H_BP        = 48,
    parameter int         V_ACTIVE    = 480,
    parameter int         V_FP        = 10,
    parameter int         V_SYNC      = 2,
    parameter int         V_BP        = 33,
    parameter int         X0          = 192,
    parameter int         Y0          = 112,
    parameter int         SCALE_SHIFT = 2,
    parameter int         ROM_LAT     = 2,
    parameter logic [8:0] BG_COLOR    = 9'h000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  data,
    output logic [11:0] ad,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [2:0]  b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WIN     = 64 << SCALE_SHIFT;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_WS   = HW'(X0);
    localparam logic [HW-1:0] H_WE   = HW'(X0 + WIN);
    localparam logic [HW-1:0] H_ONE  = HW'(1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_WS   = VW'(Y0);
    localparam logic [VW-1:0] V_WE   = VW'(Y0 + WIN);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    // Flag vector layout; sync flags are kept active-high so a cleared pipeline reads as "not in sync".
    localparam int NF      = 5;
    localparam int F_DE    = 4;
    localparam int F_HS    = 3;
    localparam int F_VS    = 2;
    localparam int F_WIN   = 1;
    localparam int F_FIRST = 0;

    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] hcnt_nxt_s;
    logic [VW-1:0] vcnt_r;
    logic [VW-1:0] vcnt_nxt_s;
    logic [5:0]    x_img_s;
    logic [5:0]    y_img_s;
    logic [NF-1:0] flags_s;
    logic [NF-1:0] flag_sr_r [ROM_LAT];
    logic [NF-1:0] flags_d_s;
    logic [11:0]   ad_r;
    logic [8:0]    pix_s;
    logic [8:0]    rgb_r;
    logic          de_r;
    logic          hs_r;
    logic          vs_r;
    logic          fs_r;

    // Raster counter next state: hcnt wraps each line, vcnt steps on that wrap.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        vcnt_nxt_s = vcnt_r;
        if (hcnt_r == H_LAST) begin
            hcnt_nxt_s = {HW{1'b0}};
            if (vcnt_r == V_LAST) begin
                vcnt_nxt_s = {VW{1'b0}};
            end else begin
                vcnt_nxt_s = vcnt_r + V_ONE;
            end
        end else begin
            hcnt_nxt_s = hcnt_r + H_ONE;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt_r <= {HW{1'b0}};
            vcnt_r <= {VW{1'b0}};
        end else begin
            hcnt_r <= hcnt_nxt_s;
            vcnt_r <= vcnt_nxt_s;
        end
    end

    // Timing flags and image coordinates decoded from the current counter state.
    always_comb begin
        x_img_s          = 6'((hcnt_r - H_WS) >> SCALE_SHIFT);
        y_img_s          = 6'((vcnt_r - V_WS) >> SCALE_SHIFT);
        flags_s[F_DE]    = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
        flags_s[F_HS]    = (hcnt_r >= H_SS) && (hcnt_r < H_SE);
        flags_s[F_VS]    = (vcnt_r >= V_SS) && (vcnt_r < V_SE);
        flags_s[F_WIN]   = (hcnt_r >= H_WS) && (hcnt_r < H_WE) &&
                           (vcnt_r >= V_WS) && (vcnt_r < V_WE);
        flags_s[F_FIRST] = (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
    end

    // ROM address: holding outside the window means the bank bit only moves on a line's first in-window pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ad_r <= 12'h000;
        end else if (flags_s[F_WIN]) begin
            ad_r <= {y_img_s, x_img_s};
        end else begin
            ad_r <= ad_r;
        end
    end

    // Flag delay line matching the ROM read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                flag_sr_r[i] <= {NF{1'b0}};
            end
        end else begin
            flag_sr_r[0] <= flags_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                flag_sr_r[i] <= flag_sr_r[i-1];
            end
        end
    end

    assign flags_d_s = flag_sr_r[ROM_LAT-1];

    // Pixel select: image inside the window, background elsewhere in active video, black in blanking.
    always_comb begin
        pix_s = 9'h000;
        if (flags_d_s[F_DE]) begin
            if (flags_d_s[F_WIN]) begin
                pix_s = data;
            end else begin
                pix_s = BG_COLOR;
            end
        end else begin
            pix_s = 9'h000;
        end
    end

    // Output register stage for pixel, syncs and enables.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb_r <= 9'h000;
            de_r  <= 1'b0;
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            fs_r  <= 1'b0;
        end else begin
            rgb_r <= pix_s;
            de_r  <= flags_d_s[F_DE];
            hs_r  <= ~flags_d_s[F_HS];
            vs_r  <= ~flags_d_s[F_VS];
            fs_r  <= flags_d_s[F_FIRST];
        end
    end

    assign ad          = ad_r;
    assign r           = rgb_r[8:6];
    assign g           = rgb_r[5:3];
    assign b           = rgb_r[2:0];
    assign de          = de_r;
    assign hsync       = hs_r;
    assign vsync       = vs_r;
    assign frame_start = fs_r;

endmodule

// File: tb/tb_image_scanout.sv
// Scoreboard bench for image_scanout on a reduced raster (168x148 total, 2x replication)
// so two full frames plus a mid-frame reset fit in a short run.
module tb_image_scanout;

    localparam int H_TOTAL = 168;
    localparam int V_TOTAL = 148;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam logic [8:0]  BG   = 9'h1C7;
    localparam logic [12:0] IDLE = 13'h006;

    typedef struct {
        logic [12:0] vec;
        int          h;
        int          v;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [8:0]  data;
    logic [11:0] ad;
    logic [2:0]  r, g, b;
    logic        de, hsync, vsync, frame_start;

    image_scanout #(
        .H_ACTIVE(148), .H_FP(4), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(140), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .X0(12), .Y0(8), .SCALE_SHIFT(1), .ROM_LAT(2), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .resetn(resetn), .data(data), .ad(ad),
        .r(r), .g(g), .b(b), .de(de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Two-bank ROM: address register lives in the DUT, output register here, bank mux on current ad[11].
    logic [8:0] bank0 [2048];
    logic [8:0] bank1 [2048];
    logic [8:0] rom_lo, rom_hi;
    initial begin
        for (int k = 0; k < 2048; k++) begin
            bank0[k] = 9'(k);
            bank1[k] = 9'(k + 2048);
        end
    end
    always @(posedge clk) begin
        rom_lo <= bank0[ad[10:0]];
        rom_hi <= bank1[ad[10:0]];
    end
    assign data = ad[11] ? rom_hi : rom_lo;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h >= 12) && (h < 140) && (v >= 8) && (v < 136);
    endfunction

    function automatic logic [12:0] exp_vec(input int h, input int v);
        logic       de_e, hs_e, vs_e, fs_e;
        logic [8:0] pix;
        int         k;
        de_e = (h < 148) && (v < 140);
        hs_e = !((h >= 152) && (h < 160));
        vs_e = !((v >= 142) && (v < 144));
        fs_e = (h == 0) && (v == 0);
        k    = ((v - 8) / 2) * 64 + ((h - 12) / 2);
        if (!de_e)             pix = 9'h000;
        else if (in_win(h, v)) pix = 9'(k);
        else                   pix = BG;
        return {pix, de_e, hs_e, vs_e, fs_e};
    endfunction

    exp_t q[$];
    int   m_h = 0, m_v = 0;
    int   last_h = 0, last_v = 0;
    logic last_valid = 1'b0;
    int   gap = 1000, prev_gap = 1000;

    // Model: each consumed raster position queues the output it must produce.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_h = 0; m_v = 0; q.delete(); last_valid = 1'b0; gap = 1000; prev_gap = 1000;
            end else begin
                e.vec = exp_vec(m_h, m_v); e.h = m_h; e.v = m_v;
                q.push_back(e);
                last_h = m_h; last_v = m_v; last_valid = 1'b1;
                prev_gap = gap;
                if (in_win(m_h, m_v)) gap = 0; else gap++;
                if (m_h == H_TOTAL - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end
        end
    end

    int tab_h [9] = '{12, 14, 138, 140, 0, 11,   12,   13,   14};
    int tab_v [9] = '{8,  8,  10,  8,   9, 72,   72,   72,   72};
    int tab_a [9] = '{0,  1,  127, 63,  63, 2047, 2048, 2048, 2049};

    // Monitor: pops the scoreboard, checks directed addresses and bank-bit stability.
    initial begin
        exp_t        e;
        logic [12:0] act;
        logic        prev_bank = 1'b0;
        forever begin
            @(negedge clk);
            act = {r, g, b, de, hsync, vsync, frame_start};
            if (resetn && q.size() >= 3) begin
                e = q.pop_front();
                check($sformatf("pix(%0d,%0d)", e.h, e.v), int'(act), int'(e.vec));
            end else begin
                check("idle_out", int'(act), int'(IDLE));
            end
            if (resetn && last_valid) begin
                for (int i = 0; i < 9; i++) begin
                    if (last_h == tab_h[i] && last_v == tab_v[i])
                        check($sformatf("ad(%0d,%0d)", last_h, last_v), int'(ad), tab_a[i]);
                end
                if (ad[11] != prev_bank)
                    check("bank_hold", (prev_gap >= 2) ? 1 : 0, 1);
            end
            prev_bank = ad[11];
        end
    end

    task automatic fs_latency(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (frame_start) break;
        end
    endtask

    initial begin
        int n, hs_lo, vs_lo, de_hi, fs_cnt, last_hf, last_vf, last_fs;
        logic prev_hs, prev_vs, hit;

        resetn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ad", int'(ad), 0);
        check("rst_de", int'(de), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_rgb", int'({r, g, b}), 0);
        check("rst_fs", int'(frame_start), 0);

        resetn = 1'b1;
        fs_latency(n);
        check("fs_latency", n, 3);
        check("de_at_start", int'(de), 1);

        hs_lo = 0; vs_lo = 0; de_hi = 0; fs_cnt = 0;
        last_hf = -1; last_vf = -1; last_fs = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (de) de_hi++;
            if (!hsync && prev_hs) begin
                if (last_hf >= 0) check("hsync_period", i - last_hf, H_TOTAL);
                last_hf = i;
            end
            if (!vsync && prev_vs) begin
                if (last_vf >= 0) check("vsync_period", i - last_vf, FRAME);
                last_vf = i;
            end
            if (frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) check("fs_period", i - last_fs, FRAME);
                last_fs = i;
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
        check("hsync_low_cycles", hs_lo, 2 * 148 * 8);
        check("vsync_low_cycles", vs_lo, 2 * 2 * H_TOTAL);
        check("de_high_cycles", de_hi, 2 * 140 * 148);
        check("fs_count", fs_cnt, 2);

        hit = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (m_v == 100 && m_h == 50) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_line_100", int'(hit), 1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_ad", int'(ad), 0);
        check("midrst_de", int'(de), 0);
        check("midrst_hsync", int'(hsync), 1);
        check("midrst_vsync", int'(vsync), 1);
        check("midrst_rgb", int'({r, g, b}), 0);
        check("midrst_fs", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        fs_latency(n);
        check("midrst_fs_latency", n, 3);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/image_scanout.md
# image_scanout

Video scan-out stage that drives the image ROM and consumes its output. It generates 640x480 VGA-class raster timing and addresses a 64x64-pixel, 9-bit (RGB333) image held in a two-bank ROM (12-bit address, bank select on address bit 11, 2-cycle registered read). The image is pixel-replicated and placed at a fixed offset on the screen. ROM data is realigned with delayed sync/blanking to produce registered RGB333, hsync, vsync and de for the video encoder.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48, horizontal porch and sync widths
- V_ACTIVE, 480, active lines
- V_FP, 10; V_SYNC, 2; V_BP, 33, vertical porch and sync widths
- X0, 192; Y0, 112, screen position of the image's top-left pixel
- SCALE_SHIFT, 2, replication factor 2^SCALE_SHIFT in each axis (default gives 256x256 on screen)
- ROM_LAT, 2, cycles from `ad` to valid `data`
- BG_COLOR, 9'h000, RGB333 value shown outside the image window
- clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- data  in  9  ROM read data, {r[2:0], g[2:0], b[2:0]}
- ad  out  12  ROM address, {y_img[5:0], x_img[5:0]}
- r, g, b  out  3 each  pixel colour
- de  out  1  active-video enable
- hsync, vsync  out  1 each  syncs, active-low
- frame_start  out  1  one-cycle pulse with the first active pixel of each frame

## Operation
- Raster counters: hcnt counts 0..H_TOTAL-1 (800) and vcnt counts 0..V_TOTAL-1 (525). vcnt steps when hcnt wraps. Both wrap to 0.
- Each line is laid out as active, front porch, sync, back porch, starting at hcnt=0. Frames use the same order starting at vcnt=0.
- Image window: X0 <= hcnt < X0+(64<<SCALE_SHIFT) and Y0 <= vcnt < Y0+(64<<SCALE_SHIFT).
  - x_img = (hcnt-X0)>>SCALE_SHIFT
  - y_img = (vcnt-Y0)>>SCALE_SHIFT
  - Subtraction is done at counter width and the result is truncated to 6 bits.
- `ad` is registered. It loads {y_img, x_img} when the counters are inside the window and holds its last value otherwise.
- Required consequence of the hold rule: ad[11] changes only on the first in-window pixel of a line. It is therefore constant for at least ROM_LAT cycles after any in-window read, which keeps the ROM's output bank mux aligned with in-flight data.
- Pipeline depth P = ROM_LAT+1 (3). The flags de_raw, hs_raw, vs_raw, in_win and first_pix are derived from the counters. They pass through a ROM_LAT-deep shift register, then an output register together with the pixel.
- Output stage: {r,g,b} = in_win_d ? data : BG_COLOR when de_d = 1, and 0 when de_d = 0.
- frame_start is first_pix (hcnt=0, vcnt=0) delayed by P.

## Timing
- Reset (resetn=0, asynchronous, no clock needed): hcnt=vcnt=0, ad=0, r=g=b=0, de=0, hsync=vsync=1, frame_start=0, all pipeline flags cleared.
- Deassertion: the first rising edge afterwards advances hcnt to 1. Outputs for hcnt=0 appear after the P-th edge, so de=1 and frame_start=1 after edge 3.
- Every output registered at edge n describes the counter state at edge n-P. Sync widths and periods are therefore exact, only shifted by P.
- `ad` follows the counters by 1 cycle. `data` is used ROM_LAT cycles after `ad`.
- hsync is low for hcnt 656..751. vsync is low for vcnt 490..491, for whole lines.
- Reset asserted mid-frame forces the reset values immediately. After release the frame restarts at (0,0), with no partial-pipeline pixels emitted.

## Test plan
- Reset/startup: hold resetn=0 for 5 cycles, then release -> during reset ad=0, de=0, hsync=vsync=1, rgb=0. After edge 3, de=1 and frame_start=1 for exactly one cycle.
- Address mapping with a ROM model (data = bank[ad[11]][ad[10:0]], 2-cycle latency):
  - (hcnt,vcnt)=(192,112) -> ad=0
  - (196,112) -> ad=1
  - (444,116) -> ad=127
  - (192,240) -> ad=2048
  - outside the window, ad holds its prior value.
- Pixel alignment: ROM word at address k = k[8:0] -> the output at screen position (192+4i, 112+4j) equals (64j+i)[8:0], repeated over 4 pixels and 4 lines. No off-by-one column at the window edges.
- Background: BG_COLOR=9'h1C7 -> pixels at hcnt 191 and 448 are r=7,g=0,b=7. During blanking rgb=0 and de=0.
- Sync/period: count over 2 frames -> hsync low for 96 cycles every 800, vsync low for 1600 cycles every 420000, de high for 640 of every 800 cycles on 480 lines.
- Bank stability and mid-frame reset:
  - ad[11] must never change within 3 cycles of an in-window read, across the line 239→240 boundary.
  - Pull resetn low at vcnt=300 -> outputs go to reset values in the same cycle, and the next frame_start occurs 3 edges after release.
